// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and the single-cycle result/flag function shared by alu_mc.
package alu_pkg;
  localparam int MAXW = 64;
  typedef logic [MAXW:0] wide_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_GT, OP_SHL1A, OP_SHL1B,
    OP_SHLV, OP_SHRV, OP_MUL, OP_ADDC
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef struct packed {
    logic [MAXW-1:0] r;
    logic z, n, c, v;
  } res_t;
  function automatic logic bit_at(input wide_t x, input int unsigned i);
    return ((x >> i) & wide_t'(1)) != '0;
  endfunction
  // Operands are zero-extended to MAXW; w selects the live width so any WIDTH <= MAXW works.
  function automatic res_t alu_single(input logic [3:0] op, input logic [MAXW-1:0] a, b,
                                      input logic cin, input int unsigned w);
    wide_t m, x, y, s, r;
    logic sa, sb, sr;
    res_t o;
    o = '0;
    m = (wide_t'(1) << w) - wide_t'(1);
    x = {1'b0, a} & m;
    y = {1'b0, b} & m;
    sa = bit_at(x, w - 1);
    sb = bit_at(y, w - 1);
    case (op)
      OP_SUB:   begin s = x - y; o.c = x < y; end
      OP_AND:   s = x & y;
      OP_OR:    s = x | y;
      OP_XOR:   s = x ^ y;
      OP_GT:    s = wide_t'(x > y);
      OP_SHL1A: begin s = x << 1; o.c = sa; end
      OP_SHL1B: begin s = y << 1; o.c = sb; end
      OP_SHLV, OP_SHRV: s = x;
      OP_ADDC:  begin s = x + y + wide_t'(cin); o.c = bit_at(s, w); end
      default:  begin s = x + y; o.c = bit_at(s, w); end
    endcase
    r = s & m;
    sr = bit_at(r, w - 1);
    o.v = (op == OP_SUB) ? (sa != sb && sr != sa) :
          (op inside {OP_AND, OP_OR, OP_XOR, OP_GT, OP_SHL1A, OP_SHL1B, OP_SHLV, OP_SHRV}) ? 1'b0 :
          (sa == sb && sr != sa);
    o.r = r[MAXW-1:0];
    o.z = r == '0;
    o.n = sr;
    return o;
  endfunction
endpackage

// File: rtl/alu_iter.sv
// alu_iter: one-bit-per-cycle variable shift and shift-add multiply engine.
module alu_iter import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter bit MUL_EN = 1,
  parameter int KW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c
);
  localparam int CW = KW + 1;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum;
  logic mul, left, mul_op;
  assign mul_op = MUL_EN && op == OP_MUL;
  // Multiply keeps the partial product in the high half and consumes multiplier bits from the low half.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    acc_n = mul ? {sum, acc[WIDTH-1:1]} :
            left ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0} :
                   {acc[2*WIDTH-1:WIDTH], 1'b0, acc[WIDTH-1:1]};
    c = mul ? |acc_n[2*WIDTH-1:WIDTH] : left ? acc[WIDTH-1] : acc[0];
  end
  assign result = acc_n[WIDTH-1:0];
  assign done = cnt == CW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mcand <= '0;
      cnt <= '0;
      mul <= 1'b0;
      left <= 1'b0;
    end else if (start) begin
      acc <= {{WIDTH{1'b0}}, (mul_op ? b : a)};
      mcand <= a;
      mul <= mul_op;
      left <= op == OP_SHLV;
      cnt <= mul_op ? CW'(WIDTH) : CW'(k);
    end else if (cnt != '0) begin
      acc <= acc_n;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes, registered flags and persistent carry.
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter bit MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);
  localparam int KW = $clog2(WIDTH);
  state_t st;
  logic [3:0] op_e;
  logic [KW-1:0] k;
  logic go_busy, accept, writes_c, it_done, it_c, carry_q, unused_r;
  logic [WIDTH-1:0] it_res;
  res_t f;
  assign k = b[KW-1:0];
  assign op_e = (op > 4'd11 || (!MUL_EN && op == OP_MUL)) ? OP_ADD : op;
  assign go_busy = op_e == OP_MUL || ((op_e == OP_SHLV || op_e == OP_SHRV) && k != '0);
  assign writes_c = op_e == OP_ADD || op_e == OP_SUB || op_e == OP_ADDC;
  assign accept = st == S_IDLE && in_valid;
  assign in_ready = st == S_IDLE;
  assign out_valid = st == S_DONE;
  always_comb f = alu_single(op_e, MAXW'(a), MAXW'(b), carry_q, WIDTH);
  assign unused_r = ^f.r;
  alu_iter #(.WIDTH(WIDTH), .MUL_EN(MUL_EN)) u_iter (
    .clk(clk), .rst_n(rst_n), .start(accept && go_busy), .op(op_e), .a(a), .b(b), .k(k),
    .done(it_done), .result(it_res), .c(it_c)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_IDLE;
      result <= '0;
      {flag_z, flag_n, flag_c, flag_v} <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      st <= go_busy ? S_BUSY : S_DONE;
      if (!go_busy) begin
        result <= f.r[WIDTH-1:0];
        {flag_z, flag_n, flag_c, flag_v} <= {f.z, f.n, f.c, f.v};
        if (writes_c) carry_q <= f.c;
      end
    end else if (st == S_BUSY && it_done) begin
      st <= S_DONE;
      result <= it_res;
      {flag_z, flag_n, flag_c, flag_v} <= {it_res == '0, it_res[WIDTH-1], it_c, 1'b0};
    end else if (st == S_DONE && out_ready) begin
      st <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table, corner-case sequences and randomized model check for alu_mc (WIDTH=8).
module tb_alu_mc;
  logic clk = 0, rst_n = 0, in_valid = 0, iv2 = 0, out_ready = 0;
  logic [3:0] op = 0;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid, flag_z, flag_n, flag_c, flag_v;
  logic in_ready2, out_valid2, flag_z2, flag_n2, flag_c2, flag_v2;
  logic [7:0] result, result2;
  int checks = 0, errors = 0;

  alu_mc #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v));
  alu_mc #(.WIDTH(8), .MUL_EN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(in_ready2), .op(op), .a(a), .b(b),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
    .flag_z(flag_z2), .flag_n(flag_n2), .flag_c(flag_c2), .flag_v(flag_v2));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, r;
    logic [3:0] f;
    int lat;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void add(input logic [3:0] o, input logic [7:0] x, y, r, input logic [3:0] f, input int l);
    vt.push_back('{o, x, y, r, f, l});
  endfunction

  // Plain-arithmetic reference: flags packed {z,n,c,v}; cout is the carry the ALU should remember.
  function automatic void model(input int o, x, y, input bit cin, output logic [7:0] r,
                                output logic [3:0] f, output int lat, output bit cout);
    int s, k, sx, sy, d;
    bit c, v;
    c = 0; v = 0; lat = 1; cout = cin; k = y % 8;
    sx = x >= 128 ? x - 256 : x;
    sy = y >= 128 ? y - 256 : y;
    case (o)
      1: begin s = x - y; c = x < y; d = sx - sy; v = d > 127 || d < -128; cout = c; end
      2: s = x & y;
      3: s = x | y;
      4: s = x ^ y;
      5: s = x > y ? 1 : 0;
      6: begin s = x * 2; c = x >= 128; end
      7: begin s = y * 2; c = y >= 128; end
      8: begin s = x << k; c = k != 0 && ((x >> (8 - k)) & 1) == 1; lat = k + 1; end
      9: begin s = x >> k; c = k != 0 && ((x >> (k - 1)) & 1) == 1; lat = k + 1; end
      10: begin s = x * y; c = s > 255; lat = 9; end
      11: begin s = x + y + int'(cin); c = s > 255; d = sx + sy + int'(cin); v = d > 127 || d < -128; cout = c; end
      default: begin s = x + y; c = s > 255; d = sx + sy; v = d > 127 || d < -128; cout = c; end
    endcase
    s = s & 255;
    r = 8'(s);
    f = {s == 0, s >= 128, c, v};
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [7:0] x, y, output logic [7:0] r,
                        output logic [3:0] f, output int lat, output logic rdy_bad);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    op = o; a = x; b = y; in_valid = 1;
    @(negedge clk);
    in_valid = 0; lat = 1; rdy_bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad = 1;
      @(negedge clk);
      lat++;
    end
    if (in_ready) rdy_bad = 1;
    r = result;
    f = {flag_z, flag_n, flag_c, flag_v};
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r, er;
    logic [3:0] f, ef;
    int lat, elat;
    logic rb;
    bit mc, nc;
    add(0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1);
    add(11, 8'h00, 8'h00, 8'h01, 4'b0000, 1);
    add(1, 8'h05, 8'h07, 8'hFE, 4'b0110, 1);
    add(0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1);
    add(10, 8'h10, 8'h11, 8'h10, 4'b0010, 9);
    add(8, 8'h81, 8'h03, 8'h08, 4'b0000, 4);
    add(9, 8'h81, 8'h01, 8'h40, 4'b0010, 2);
    add(8, 8'h81, 8'h00, 8'h81, 4'b0100, 1);
    add(9, 8'h80, 8'h07, 8'h01, 4'b0000, 8);
    add(2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
    add(3, 8'h0F, 8'hF0, 8'hFF, 4'b0100, 1);
    add(4, 8'hAA, 8'hAA, 8'h00, 4'b1000, 1);
    add(5, 8'h80, 8'h7F, 8'h01, 4'b0000, 1);
    add(5, 8'h7F, 8'h80, 8'h00, 4'b1000, 1);
    add(6, 8'hC0, 8'h00, 8'h80, 4'b0110, 1);
    add(7, 8'h00, 8'h40, 8'h80, 4'b0100, 1);
    add(1, 8'h80, 8'h01, 8'h7F, 4'b0001, 1);
    add(12, 8'h03, 8'h04, 8'h07, 4'b0000, 1);
    add(11, 8'h80, 8'h80, 8'h00, 4'b1011, 1);
    add(11, 8'h01, 8'h01, 8'h03, 4'b0000, 1);
    add(10, 8'hFF, 8'hFF, 8'h01, 4'b0010, 9);
    add(10, 8'h00, 8'h55, 8'h00, 4'b1000, 9);

    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v}, {1'b1, 1'b0, 8'h00, 4'b0000});
    @(negedge clk);
    rst_n = 1;

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, r, f, lat, rb);
      chk($sformatf("vec%0d_result", i), r, vt[i].r);
      chk($sformatf("vec%0d_flags", i), f, vt[i].f);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      if (vt[i].lat > 1) chk($sformatf("vec%0d_in_ready_low", i), rb, 0);
    end

    // MUL decoded as ADD when the multiplier is disabled
    @(negedge clk);
    op = 10; a = 8'h10; b = 8'h11; iv2 = 1;
    @(negedge clk);
    iv2 = 0;
    chk("mul_en0", {out_valid2, result2, flag_z2, flag_n2, flag_c2, flag_v2}, {1'b1, 8'h21, 4'b0000});
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("mul_en0_idle", {in_ready2, out_valid2}, 2'b10);

    // Backpressure: result held, no capture while DONE
    @(negedge clk);
    op = 0; a = 8'h03; b = 8'h04; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("bp_done", {out_valid, result}, {1'b1, 8'h07});
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2) == 0;
      op = 1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, flag_z, flag_n, flag_c, flag_v, result},
          {1'b1, 1'b0, 4'b0000, 8'h07});
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_release", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    chk("bp_no_capture", {in_ready, out_valid}, 2'b10);

    // Reset during MUL iteration
    run_op(0, 8'hFF, 8'h01, r, f, lat, rb);
    chk("rst_pre_carry", f, 4'b1010);
    @(negedge clk);
    op = 10; a = 8'h10; b = 8'h11; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_mul", {out_valid, in_ready, result}, {1'b0, 1'b1, 8'h00});
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("rst_abandoned", {out_valid, in_ready}, 2'b01);
    run_op(11, 8'h00, 8'h00, r, f, lat, rb);
    chk("rst_addc_result", r, 8'h00);
    chk("rst_addc_flags", f, 4'b1000);

    mc = 0;
    for (int i = 0; i < 150; i++) begin
      int o, x, y;
      o = int'($urandom_range(0, 15));
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      model(o, x, y, mc, er, ef, elat, nc);
      run_op(4'(o), 8'(x), 8'(y), r, f, lat, rb);
      chk($sformatf("rnd%0d_op%0d_result", i, o), r, er);
      chk($sformatf("rnd%0d_op%0d_flags", i, o), f, ef);
      chk($sformatf("rnd%0d_op%0d_latency", i, o), lat, elat);
      mc = nc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
